// File: rtl/freq_pulse_gen.sv
// rtl/freq_pulse_gen.sv - programmable square-wave / tick generator with shadowed config
//
// Purpose:
//   Generates a registered square wave (clk_out) with a programmable half-period,
//   a strobe (tick) on each rising edge of clk_out, and an optional pulse count after
//   which the generator returns to idle. New configurations are staged in a single
//   shadow register and are applied only at a period boundary, so the running
//   waveform is never shortened or stretched.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-high reset
//   enable           run request, sampled in IDLE and on the last LOW cycle
//   cfg_valid        config offer; transfer on cfg_valid && cfg_ready
//   cfg_ready        shadow register empty
//   cfg_half_period  cycles per phase (0 behaves as 1)
//   cfg_pulse_count  periods to generate before stopping (0 = run forever)
//   clk_out          generated waveform
//   tick             one-cycle strobe on the first HIGH cycle of each period
//   busy             generator is in HIGH or LOW
//   done             one-cycle strobe on the first IDLE cycle after running
//   pulse_cnt        periods started since the last config load
module freq_pulse_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_half_period,
  input  logic [DATA_WIDTH-1:0] cfg_pulse_count,
  output logic                  clk_out,
  output logic                  tick,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] phase_cnt_q, phase_cnt_d;
  logic [DATA_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [DATA_WIDTH-1:0] act_half_q, act_half_d;
  logic [DATA_WIDTH-1:0] act_count_q, act_count_d;
  logic [DATA_WIDTH-1:0] shadow_half_q, shadow_half_d;
  logic [DATA_WIDTH-1:0] shadow_count_q, shadow_count_d;
  logic                  shadow_full_q, shadow_full_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  clk_out_q, clk_out_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;

  logic                  xfer;
  logic                  load;
  logic [DATA_WIDTH-1:0] half_m1;
  logic                  phase_last;

  always_comb begin
    state_d        = state_q;
    phase_cnt_d    = phase_cnt_q;
    pulse_cnt_d    = pulse_cnt_q;
    act_half_d     = act_half_q;
    act_count_d    = act_count_q;
    shadow_half_d  = shadow_half_q;
    shadow_count_d = shadow_count_q;
    shadow_full_d  = shadow_full_q;
    tick_d         = 1'b0;
    done_d         = 1'b0;
    load           = 1'b0;

    xfer = cfg_valid && cfg_ready_q;

    // A half-period of 0 behaves as 1, so the terminal phase count is 0 in both cases.
    half_m1    = (act_half_q == '0) ? '0 : act_half_q - ONE;
    phase_last = (phase_cnt_q == half_m1);

    case (state_q)
      ST_IDLE: begin
        if (enable && shadow_full_q) begin
          load        = 1'b1;
          state_d     = ST_HIGH;
          tick_d      = 1'b1;
          pulse_cnt_d = ONE;
          phase_cnt_d = '0;
        end
      end
      ST_HIGH: begin
        if (phase_last) begin
          state_d     = ST_LOW;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + ONE;
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          // Period boundary: stop requests win over count expiry, which wins over reload.
          if (!enable) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if ((act_count_q != '0) && (pulse_cnt_q == act_count_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (shadow_full_q) begin
            load        = 1'b1;
            state_d     = ST_HIGH;
            tick_d      = 1'b1;
            pulse_cnt_d = ONE;
            phase_cnt_d = '0;
          end else begin
            state_d     = ST_HIGH;
            tick_d      = 1'b1;
            pulse_cnt_d = pulse_cnt_q + ONE;
            phase_cnt_d = '0;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        phase_cnt_d = '0;
      end
    endcase

    if (load) begin
      act_half_d    = shadow_half_q;
      act_count_d   = shadow_count_q;
      shadow_full_d = 1'b0;
    end

    // xfer requires an empty shadow and load requires a full one, so they never overlap.
    if (xfer) begin
      shadow_full_d  = 1'b1;
      shadow_half_d  = cfg_half_period;
      shadow_count_d = cfg_pulse_count;
    end

    cfg_ready_d = ~shadow_full_d;
    clk_out_d   = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      phase_cnt_q    <= '0;
      pulse_cnt_q    <= '0;
      act_half_q     <= '0;
      act_count_q    <= '0;
      shadow_half_q  <= '0;
      shadow_count_q <= '0;
      shadow_full_q  <= 1'b0;
      cfg_ready_q    <= 1'b1;
      clk_out_q      <= 1'b0;
      tick_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_cnt_q    <= phase_cnt_d;
      pulse_cnt_q    <= pulse_cnt_d;
      act_half_q     <= act_half_d;
      act_count_q    <= act_count_d;
      shadow_half_q  <= shadow_half_d;
      shadow_count_q <= shadow_count_d;
      shadow_full_q  <= shadow_full_d;
      cfg_ready_q    <= cfg_ready_d;
      clk_out_q      <= clk_out_d;
      tick_q         <= tick_d;
      done_q         <= done_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_freq_pulse_gen.sv
// tb/tb_freq_pulse_gen.sv - self-checking bench for freq_pulse_gen
//
// Purpose:
//   Drives directed configuration/enable/reset scenarios and checks every cycle
//   against a period-position model, plus hand-computed cycle-indexed expectations.
//
// Ports: none (top-level bench).
module tb_freq_pulse_gen;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_half_period = '0;
  logic [DW-1:0] cfg_pulse_count = '0;
  logic          clk_out;
  logic          tick;
  logic          busy;
  logic          done;
  logic [DW-1:0] pulse_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;

  freq_pulse_gen #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_half_period (cfg_half_period),
    .cfg_pulse_count (cfg_pulse_count),
    .clk_out         (clk_out),
    .tick            (tick),
    .busy            (busy),
    .done            (done),
    .pulse_cnt       (pulse_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: the generator is either idle or at position m_pos within a 2*m_h period.
  bit          m_run;
  bit          m_done;
  bit          m_sh_full;
  longint      m_pos;
  longint      m_h;
  logic [31:0] m_cnt;
  logic [31:0] m_pulses;
  logic [31:0] m_sh_half;
  logic [31:0] m_sh_cnt;

  function automatic void m_reset();
    m_run = 0; m_done = 0; m_sh_full = 0;
    m_pos = 0; m_h = 0; m_cnt = '0; m_pulses = '0;
    m_sh_half = '0; m_sh_cnt = '0;
  endfunction

  function automatic void m_load();
    m_h       = (m_sh_half == 0) ? 64'sd1 : longint'(m_sh_half);
    m_cnt     = m_sh_cnt;
    m_sh_full = 0;
    m_pos     = 0;
    m_pulses  = 32'd1;
    m_run     = 1;
  endfunction

  function automatic void m_step();
    bit xfer;
    xfer   = cfg_valid && !m_sh_full;
    m_done = 0;
    if (!m_run) begin
      if (enable && m_sh_full) m_load();
    end else if (m_pos == 2 * m_h - 1) begin
      if (!enable || (m_cnt != 0 && m_pulses == m_cnt)) begin
        m_run  = 0;
        m_done = 1;
      end else if (m_sh_full) begin
        m_load();
      end else begin
        m_pos    = 0;
        m_pulses = m_pulses + 32'd1;
      end
    end else begin
      m_pos++;
    end
    if (xfer) begin
      m_sh_full = 1;
      m_sh_half = cfg_half_period;
      m_sh_cnt  = cfg_pulse_count;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else m_step();
    #1;
    check("model clk_out",   clk_out,   (m_run && m_pos < m_h));
    check("model tick",      tick,      (m_run && m_pos == 0));
    check("model busy",      busy,      m_run);
    check("model done",      done,      m_done);
    check("model pulse_cnt", pulse_cnt, m_pulses);
    check("model cfg_ready", cfg_ready, !m_sh_full);
  end

  // Called just after a negedge; returns at the negedge following the transfer edge.
  task automatic push(input logic [31:0] h, input logic [31:0] c);
    int n = 0;
    cfg_valid       = 1'b1;
    cfg_half_period = h;
    cfg_pulse_count = c;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL push timeout: cfg_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic mark();
    base = cyc;
  endtask

  // Advance to the middle of cycle k relative to mark().
  task automatic at(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle timeout: busy got 1 after %0d cycles, required 0", n);
    end
  endtask

  bit [1:12] t1_clk  = 12'b111000111000;
  bit [1:12] t1_tick = 12'b100000100000;

  initial begin
    #3 reset = 1'b1;
    #1;
    check("reset clk_out",   clk_out,   0);
    check("reset tick",      tick,      0);
    check("reset busy",      busy,      0);
    check("reset done",      done,      0);
    check("reset pulse_cnt", pulse_cnt, 0);
    check("reset cfg_ready", cfg_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: H=3, count=2
    enable = 1'b1;
    push(32'd3, 32'd2);
    mark();
    for (int k = 1; k <= 12; k++) begin
      at(k);
      check($sformatf("t1 clk_out c%0d", k), clk_out, t1_clk[k]);
      check($sformatf("t1 tick c%0d", k),    tick,    t1_tick[k]);
    end
    at(13);
    check("t1 done c13",      done,      1);
    check("t1 busy c13",      busy,      0);
    check("t1 pulse_cnt c13", pulse_cnt, 2);
    at(14);
    check("t1 done c14",      done,      0);
    check("t1 pulse_cnt c14", pulse_cnt, 2);

    // 2: H=0 behaves as 1, count=4
    push(32'd0, 32'd4);
    mark();
    for (int k = 1; k <= 8; k++) begin
      at(k);
      check($sformatf("t2 clk_out c%0d", k), clk_out, (k % 2));
      check($sformatf("t2 tick c%0d", k),    tick,    (k % 2));
    end
    at(9);
    check("t2 done c9",      done,      1);
    check("t2 busy c9",      busy,      0);
    check("t2 pulse_cnt c9", pulse_cnt, 4);

    // 3: continuous H=2, H=5 pushed during the first HIGH
    push(32'd2, 32'd0);
    mark();
    at(1);
    push(32'd5, 32'd0);
    at(2);
    check("t3 cfg_ready c2", cfg_ready, 0);
    at(4);
    check("t3 clk_out c4",   clk_out,   0);
    check("t3 cfg_ready c4", cfg_ready, 0);
    check("t3 pulse_cnt c4", pulse_cnt, 1);
    at(5);
    check("t3 tick c5",      tick,      1);
    check("t3 clk_out c5",   clk_out,   1);
    check("t3 pulse_cnt c5", pulse_cnt, 1);
    check("t3 cfg_ready c5", cfg_ready, 1);
    at(9);
    check("t3 clk_out c9",   clk_out,   1);
    at(10);
    check("t3 clk_out c10",  clk_out,   0);
    at(14);
    check("t3 clk_out c14",  clk_out,   0);
    check("t3 tick c14",     tick,      0);
    at(15);
    check("t3 tick c15",      tick,      1);
    check("t3 pulse_cnt c15", pulse_cnt, 2);
    enable = 1'b0;
    wait_idle();
    enable = 1'b1;

    // 4: continuous H=4, enable drops in the 2nd HIGH cycle
    push(32'd4, 32'd0);
    mark();
    at(2);
    enable = 1'b0;
    at(4);
    check("t4 clk_out c4", clk_out, 1);
    at(5);
    check("t4 clk_out c5", clk_out, 0);
    at(8);
    check("t4 clk_out c8", clk_out, 0);
    check("t4 busy c8",    busy,    1);
    check("t4 done c8",    done,    0);
    at(9);
    check("t4 done c9",    done,    1);
    check("t4 busy c9",    busy,    0);
    check("t4 tick c9",    tick,    0);
    for (int k = 10; k <= 12; k++) begin
      at(k);
      check($sformatf("t4 tick c%0d", k),    tick,    0);
      check($sformatf("t4 clk_out c%0d", k), clk_out, 0);
      check($sformatf("t4 busy c%0d", k),    busy,    0);
    end
    enable = 1'b1;

    // 5: async reset in the middle of a LOW phase with a config pending
    push(32'd3, 32'd0);
    mark();
    at(1);
    push(32'd7, 32'd0);
    at(4);
    check("t5 clk_out c4",   clk_out,   0);
    check("t5 busy c4",      busy,      1);
    check("t5 cfg_ready c4", cfg_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("t5 async clk_out",   clk_out,   0);
    check("t5 async busy",      busy,      0);
    check("t5 async tick",      tick,      0);
    check("t5 async pulse_cnt", pulse_cnt, 0);
    check("t5 async cfg_ready", cfg_ready, 1);
    check("t5 async done",      done,      0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5 no restart busy",      busy,      0);
    check("t5 no restart cfg_ready", cfg_ready, 1);

    // 6: back-to-back configs while running
    push(32'd2, 32'd0);
    mark();
    at(1);
    push(32'd3, 32'd0);
    check("t6 cfg_ready c2", cfg_ready, 0);
    push(32'd1, 32'd2);
    check("t6 stall end cycle", cyc - base, 6);
    at(6);
    check("t6 clk_out c6",   clk_out,   1);
    check("t6 cfg_ready c6", cfg_ready, 0);
    check("t6 pulse_cnt c6", pulse_cnt, 1);
    at(8);
    check("t6 clk_out c8",   clk_out,   0);
    at(10);
    check("t6 clk_out c10",  clk_out,   0);
    at(11);
    check("t6 tick c11",      tick,      1);
    check("t6 pulse_cnt c11", pulse_cnt, 1);
    check("t6 cfg_ready c11", cfg_ready, 1);
    at(12);
    check("t6 clk_out c12",  clk_out,   0);
    at(13);
    check("t6 tick c13",      tick,      1);
    check("t6 pulse_cnt c13", pulse_cnt, 2);
    at(15);
    check("t6 done c15",      done,      1);
    check("t6 busy c15",      busy,      0);
    check("t6 pulse_cnt c15", pulse_cnt, 2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
